// File: rtl/mod_counter_gen.sv
// mod_counter_gen: runtime-programmable modulo-M counter with optional prescaler.
//
// The counter wraps or saturates at the modulus boundary. Its modulus comes from
// a parameter or a runtime port, and it counts up or down. A registered
// terminal-count pulse and a saturating wrap-event counter make it usable as a
// cascadable stage.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous reset, active low
//   en        in   count enable (drives the prescaler)
//   up_dn     in   1 = up, 0 = down
//   mode      in   0 = wrap at boundary, 1 = saturate at boundary
//   mod_sel   in   0 = DEFAULT_MOD, 1 = mod_val
//   mod_val   in   runtime modulus (0 means 2^WIDTH)
//   load      in   synchronous load strobe
//   load_val  in   value to load, clamped to M-1
//   count     out  current count, 0..M-1
//   tc        out  one-cycle terminal-count pulse following a boundary step
//   sat       out  high while held at the boundary in saturate mode
//   wraps     out  wrap events since reset, saturating at all-ones
module mod_counter_gen #(
    parameter int WIDTH       = 4,
    parameter int DEFAULT_MOD = 5,
    parameter int PRESCALE    = 1,
    parameter int WRAP_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              up_dn,
    input  logic              mode,
    input  logic              mod_sel,
    input  logic [WIDTH-1:0]  mod_val,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              sat,
    output logic [WRAP_W-1:0] wraps
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    // M-1 computed modulo 2^WIDTH, so a modulus of 0 yields all-ones (M = 2^WIDTH).
    localparam logic [WIDTH-1:0]  DEF_MAX  = WIDTH'(DEFAULT_MOD - 1);
    localparam logic [PW-1:0]     PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

    logic [WIDTH-1:0]  count_q, count_d;
    logic              tc_q, tc_d;
    logic              sat_q, sat_d;
    logic [WRAP_W-1:0] wraps_q, wraps_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [WIDTH-1:0]  m_max;
    logic [WIDTH-1:0]  dec_val;
    logic              step;

    always_comb begin
        m_max   = mod_sel ? (mod_val - WIDTH'(1)) : DEF_MAX;
        dec_val = count_q - WIDTH'(1);

        presc_d = presc_q;
        step    = 1'b0;
        count_d = count_q;
        tc_d    = 1'b0;
        sat_d   = sat_q;
        wraps_d = wraps_q;

        if (en) begin
            if (presc_q == PRE_LAST) begin
                presc_d = '0;
                step    = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        if (load) begin
            count_d = (load_val > m_max) ? m_max : load_val;
            sat_d   = 1'b0;
            presc_d = '0;
        end else if (step) begin
            if (up_dn) begin
                // >= rather than == so that a modulus shrunk below the current
                // count still treats the next up step as the boundary.
                if (count_q >= m_max) begin
                    if (mode) begin
                        count_d = m_max;
                        tc_d    = ~sat_q;
                        sat_d   = 1'b1;
                    end else begin
                        count_d = '0;
                        tc_d    = 1'b1;
                        sat_d   = 1'b0;
                        wraps_d = (wraps_q == WRAP_MAX) ? wraps_q : wraps_q + WRAP_W'(1);
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                    sat_d   = mode && (count_d == m_max);
                    tc_d    = sat_d;
                end
            end else begin
                if (count_q == '0) begin
                    if (mode) begin
                        count_d = '0;
                        tc_d    = ~sat_q;
                        sat_d   = 1'b1;
                    end else begin
                        count_d = m_max;
                        tc_d    = 1'b1;
                        sat_d   = 1'b0;
                        wraps_d = (wraps_q == WRAP_MAX) ? wraps_q : wraps_q + WRAP_W'(1);
                    end
                end else begin
                    count_d = (dec_val > m_max) ? m_max : dec_val;
                    sat_d   = mode && (count_d == '0);
                    tc_d    = sat_d;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            sat_q   <= 1'b0;
            wraps_q <= '0;
            presc_q <= '0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            sat_q   <= sat_d;
            wraps_q <= wraps_d;
            presc_q <= presc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign sat   = sat_q;
    assign wraps = wraps_q;

endmodule

// File: tb/tb_mod_counter_gen.sv
module tb_mod_counter_gen;

    logic       clk = 1'b0;
    logic       rst, en, up_dn, mode, mod_sel, load;
    logic [3:0] mod_val, load_val;

    logic [3:0] count_a, count_p;
    logic       tc_a, tc_p, sat_a, sat_p;
    logic [7:0] wraps_a;
    logic [1:0] wraps_p;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod_counter_gen #(.WIDTH(4), .DEFAULT_MOD(5), .PRESCALE(1), .WRAP_W(8)) dut_a (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .mode(mode), .mod_sel(mod_sel),
        .mod_val(mod_val), .load(load), .load_val(load_val),
        .count(count_a), .tc(tc_a), .sat(sat_a), .wraps(wraps_a)
    );

    mod_counter_gen #(.WIDTH(4), .DEFAULT_MOD(5), .PRESCALE(3), .WRAP_W(2)) dut_p (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .mode(mode), .mod_sel(mod_sel),
        .mod_val(mod_val), .load(load), .load_val(load_val),
        .count(count_p), .tc(tc_p), .sat(sat_p), .wraps(wraps_p)
    );

    typedef struct {
        logic       rst, en, up_dn, mode, mod_sel;
        logic [3:0] mod_val;
        logic       load;
        logic [3:0] load_val;
        logic [3:0] e_count;
        logic       e_tc, e_sat;
        logic [7:0] e_wraps;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic u, input logic m,
                       input logic ms, input logic [3:0] mv, input logic ld,
                       input logic [3:0] lv, input logic [3:0] c, input logic t,
                       input logic s, input logic [7:0] w);
        vec_t v;
        v.rst = r; v.en = e; v.up_dn = u; v.mode = m; v.mod_sel = ms;
        v.mod_val = mv; v.load = ld; v.load_val = lv;
        v.e_count = c; v.e_tc = t; v.e_sat = s; v.e_wraps = w;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic to_negedge();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; up_dn = 1'b1; mode = 1'b0; mod_sel = 1'b0;
        mod_val = 4'd0; load = 1'b0; load_val = 4'd0;

        //   rst en up md ms mv ld lv | cnt tc sat wraps
        add(0, 1, 1, 0, 0, 0,  0, 0,   0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0,  0, 0,   1, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0,  0, 0,   2, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0,  0, 0,   3, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0,  0, 0,   4, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0,  0, 0,   0, 1, 0, 1);
        add(1, 1, 1, 0, 0, 0,  0, 0,   1, 0, 0, 1);
        add(1, 1, 1, 1, 1, 6,  1, 3,   3, 0, 0, 1);
        add(1, 1, 1, 1, 1, 6,  0, 0,   4, 0, 0, 1);
        add(1, 1, 1, 1, 1, 6,  0, 0,   5, 1, 1, 1);
        add(1, 1, 1, 1, 1, 6,  0, 0,   5, 0, 1, 1);
        add(1, 1, 1, 1, 1, 6,  0, 0,   5, 0, 1, 1);
        add(1, 1, 0, 1, 1, 6,  0, 0,   4, 0, 0, 1);
        add(1, 1, 0, 1, 1, 6,  0, 0,   3, 0, 0, 1);
        add(1, 1, 1, 0, 1, 8,  1, 12,  7, 0, 0, 1);
        add(1, 1, 1, 0, 1, 8,  1, 3,   3, 0, 0, 1);
        add(1, 1, 1, 0, 1, 12, 1, 9,   9, 0, 0, 1);
        add(1, 1, 1, 0, 1, 5,  0, 0,   0, 1, 0, 2);
        add(1, 1, 1, 0, 1, 0,  1, 14, 14, 0, 0, 2);
        add(1, 1, 1, 0, 1, 0,  0, 0,  15, 0, 0, 2);
        add(1, 1, 1, 0, 1, 0,  0, 0,   0, 1, 0, 3);
        add(1, 1, 1, 0, 1, 0,  0, 0,   1, 0, 0, 3);
        add(1, 1, 1, 0, 1, 12, 1, 9,   9, 0, 0, 3);
        add(1, 1, 0, 0, 1, 5,  0, 0,   4, 0, 0, 3);
        add(1, 1, 1, 0, 1, 1,  0, 0,   0, 1, 0, 4);
        add(1, 1, 1, 0, 1, 1,  0, 0,   0, 1, 0, 5);
        add(1, 1, 0, 1, 1, 6,  1, 2,   2, 0, 0, 5);
        add(1, 1, 0, 1, 1, 6,  0, 0,   1, 0, 0, 5);
        add(1, 1, 0, 1, 1, 6,  0, 0,   0, 1, 1, 5);
        add(1, 1, 0, 1, 1, 6,  0, 0,   0, 0, 1, 5);
        add(1, 1, 1, 1, 1, 6,  0, 0,   1, 0, 0, 5);
        add(1, 0, 1, 1, 1, 6,  0, 0,   1, 0, 0, 5);
        add(1, 1, 1, 0, 0, 0,  0, 0,   2, 0, 0, 5);
        add(1, 1, 1, 0, 0, 0,  0, 0,   3, 0, 0, 5);
        add(1, 1, 1, 0, 0, 0,  0, 0,   4, 0, 0, 5);
        add(1, 1, 1, 0, 0, 0,  0, 0,   0, 1, 0, 6);
        add(0, 1, 1, 0, 0, 0,  0, 0,   0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0,  0, 0,   1, 0, 0, 0);

        to_negedge();
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; en = vecs[i].en; up_dn = vecs[i].up_dn;
            mode = vecs[i].mode; mod_sel = vecs[i].mod_sel; mod_val = vecs[i].mod_val;
            load = vecs[i].load; load_val = vecs[i].load_val;
            cycle();
            check($sformatf("vec%0d count", i), int'(count_a), int'(vecs[i].e_count));
            check($sformatf("vec%0d tc", i),    int'(tc_a),    int'(vecs[i].e_tc));
            check($sformatf("vec%0d sat", i),   int'(sat_a),   int'(vecs[i].e_sat));
            check($sformatf("vec%0d wraps", i), int'(wraps_a), int'(vecs[i].e_wraps));
            to_negedge();
        end

        // Prescaler (PRESCALE=3), down wrap from 0 with M=10, enable freeze.
        rst = 1'b0; en = 1'b1; up_dn = 1'b0; mode = 1'b0; mod_sel = 1'b1;
        mod_val = 4'd10; load = 1'b0; load_val = 4'd0;
        cycle();
        check("pre reset count", int'(count_p), 0);
        check("pre reset wraps", int'(wraps_p), 0);
        to_negedge();
        rst = 1'b1;
        cycle(); check("pre ph1 count", int'(count_p), 0); to_negedge();
        cycle(); check("pre ph2 count", int'(count_p), 0); to_negedge();
        cycle();
        check("pre step1 count", int'(count_p), 9);
        check("pre step1 tc", int'(tc_p), 1);
        check("pre step1 wraps", int'(wraps_p), 1);
        to_negedge();
        cycle();
        check("pre ph1b count", int'(count_p), 9);
        check("pre ph1b tc", int'(tc_p), 0);
        to_negedge();
        en = 1'b0;
        cycle(); to_negedge();
        cycle(); check("pre frozen count", int'(count_p), 9); to_negedge();
        en = 1'b1;
        cycle(); check("pre ph2b count", int'(count_p), 9); to_negedge();
        cycle();
        check("pre step2 count", int'(count_p), 8);
        check("pre step2 tc", int'(tc_p), 0);
        to_negedge();

        // M=1 wraps on every step; 2-bit wrap counter must stick at 3.
        mod_val = 4'd1; up_dn = 1'b1;
        for (int k = 0; k < 9; k++) begin
            cycle();
            to_negedge();
        end
        check("pre M1 count", int'(count_p), 0);
        check("pre wraps sat", int'(wraps_p), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
